// File: rtl/bsg_tb_timebase_pkg.sv
// Shared constants and types for the co-simulation timebase.
package bsg_tb_timebase_pkg;
  localparam int bsg_tb_timebase_stages_gp    = 3;
  localparam int bsg_tb_timebase_ctr_width_gp = 64;

  typedef logic [63:0] bsg_tb_ctr_t;
endpackage

// File: rtl/bsg_tb_timebase_if.sv
// Snapshot request/response bundle between a reader and the timebase.
interface bsg_tb_timebase_if
  import bsg_tb_timebase_pkg::*;
#(
  parameter int ctr_width_p = bsg_tb_timebase_ctr_width_gp
);
  logic                   sample_v_i;
  logic                   sample_v_o;
  logic [ctr_width_p-1:0] sample_r_o;

  modport master (output sample_v_i, input sample_v_o, sample_r_o);
  modport slave  (input sample_v_i, output sample_v_o, sample_r_o);
endinterface

// File: rtl/bsg_dff_chain_reset.sv
// Fixed-depth register chain with synchronous clear; zero depth is a wire.
module bsg_dff_chain_reset #(
  parameter int width_p      = 1,
  parameter int num_stages_p = 3
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic [width_p-1:0] data_i,
  output logic [width_p-1:0] data_o
);

  if (num_stages_p == 0) begin : g_pass
    logic unused_ctl;
    assign unused_ctl = ^{clk_i, reset_i};
    assign data_o     = data_i;
  end else begin : g_chain
    for (genvar k = 0; k < num_stages_p; k++) begin : g_stage
      logic [width_p-1:0] d_p0;
      logic [width_p-1:0] q_p1;

      if (k == 0) begin : g_head
        assign d_p0 = data_i;
      end else begin : g_link
        assign d_p0 = g_stage[k-1].q_p1;
      end

      // stage k register boundary
      always_ff @(posedge clk_i) begin
        if (reset_i) q_p1 <= '0;
        else         q_p1 <= d_p0;
      end
    end

    assign data_o = g_stage[num_stages_p-1].q_p1;
  end

endmodule

// File: rtl/bsg_tb_timebase.sv
// Delayed status chain, shared global cycle counter and one-cycle snapshot port.
// Define BSG_TB_TIMEBASE_SATURATE_EN to make the counter stick at all-ones.
module bsg_tb_timebase
  import bsg_tb_timebase_pkg::*;
#(
  parameter int width_p      = 1,
  parameter int num_stages_p = bsg_tb_timebase_stages_gp,
  parameter int ctr_width_p  = bsg_tb_timebase_ctr_width_gp
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic [width_p-1:0]     data_i,
  output logic [width_p-1:0]     data_o,
  output logic [ctr_width_p-1:0] ctr_r_o,
  bsg_tb_timebase_if.slave       sample_if
);

  logic [ctr_width_p-1:0] ctr_p0;
  logic                   vld_p1;
  logic [ctr_width_p-1:0] sample_r_p1;

  function automatic logic [ctr_width_p-1:0] ctr_next(input logic [ctr_width_p-1:0] c);
`ifdef BSG_TB_TIMEBASE_SATURATE_EN
    return (&c) ? c : c + 1'b1;
`else
    return c + 1'b1;
`endif
  endfunction

  bsg_dff_chain_reset #(
    .width_p     (width_p),
    .num_stages_p(num_stages_p)
  ) u_chain (
    .clk_i  (clk_i),
    .reset_i(reset_i),
    .data_i (data_i),
    .data_o (data_o)
  );

  // counter register
  always_ff @(posedge clk_i) begin
    if (reset_i) ctr_p0 <= '0;
    else         ctr_p0 <= ctr_next(ctr_p0);
  end

  // snapshot stage: captures the count visible in the request cycle
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      vld_p1      <= 1'b0;
      sample_r_p1 <= '0;
    end else begin
      vld_p1 <= sample_if.sample_v_i;
      if (sample_if.sample_v_i) sample_r_p1 <= ctr_p0;
    end
  end

  assign ctr_r_o              = ctr_p0;
  assign sample_if.sample_v_o = vld_p1;
  assign sample_if.sample_r_o = sample_r_p1;

endmodule

// File: tb/tb_bsg_tb_timebase.sv
// Directed bench: 3-stage/64-bit, 3-stage/8-bit and 0-stage/4-bit instances.
// Expectations follow BSG_TB_TIMEBASE_SATURATE_EN when it is defined.
module tb_bsg_tb_timebase;
  import bsg_tb_timebase_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       d;
  logic [3:0] d4;
  logic       sv;

  logic        q3;
  logic        q8;
  logic [3:0]  q0;
  logic [63:0] ctr3;
  logic [7:0]  ctr8;
  logic [7:0]  ctr0;

  int n_chk  = 0;
  int n_pass = 0;
  int r      = 0;

  always #5 clk = ~clk;

  bsg_tb_timebase_if #(.ctr_width_p(64)) if3 ();
  bsg_tb_timebase_if #(.ctr_width_p(8))  if8 ();
  bsg_tb_timebase_if #(.ctr_width_p(8))  if0 ();

  assign if3.sample_v_i = sv;
  assign if8.sample_v_i = sv;
  assign if0.sample_v_i = sv;

  bsg_tb_timebase #(.width_p(1), .num_stages_p(3), .ctr_width_p(64)) u3 (
    .clk_i(clk), .reset_i(rst), .data_i(d), .data_o(q3), .ctr_r_o(ctr3), .sample_if(if3.slave));
  bsg_tb_timebase #(.width_p(1), .num_stages_p(3), .ctr_width_p(8)) u8 (
    .clk_i(clk), .reset_i(rst), .data_i(d), .data_o(q8), .ctr_r_o(ctr8), .sample_if(if8.slave));
  bsg_tb_timebase #(.width_p(4), .num_stages_p(0), .ctr_width_p(8)) u0 (
    .clk_i(clk), .reset_i(rst), .data_i(d4), .data_o(q0), .ctr_r_o(ctr0), .sample_if(if0.slave));

  function automatic bsg_tb_ctr_t exp8(input int c);
`ifdef BSG_TB_TIMEBASE_SATURATE_EN
    return (c > 255) ? 64'd255 : bsg_tb_ctr_t'(c);
`else
    return bsg_tb_ctr_t'(c % 256);
`endif
  endfunction

  task automatic chk(input string tag, input bsg_tb_ctr_t obs, input bsg_tb_ctr_t exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // r tracks the cycle index since reset was last released
  task automatic tick();
    @(posedge clk);
    #1;
    if (rst) r = 0;
    else     r++;
  endtask

  task automatic run_to(input int target);
    while (r < target) begin
      tick();
      chk("ctr64", ctr3, bsg_tb_ctr_t'(r));
      chk("ctr8", bsg_tb_ctr_t'(ctr8), exp8(r));
    end
  endtask

  initial begin
    rst = 1'b1; d = 1'b1; sv = 1'b1; d4 = 4'hA;

    for (int i = 0; i < 16; i++) begin
      tick();
      chk("rst_data", bsg_tb_ctr_t'(q3), 64'd0);
      chk("rst_ctr", ctr3, 64'd0);
      chk("rst_vld", bsg_tb_ctr_t'(if3.sample_v_o), 64'd0);
      chk("rst_samp", bsg_tb_ctr_t'(if3.sample_r_o), 64'd0);
      chk("pass_rst", bsg_tb_ctr_t'(q0), 64'hA);
    end

    rst = 1'b0; d = 1'b0; sv = 1'b0;
    #1;
    chk("release_ctr", ctr3, 64'd0);
    run_to(1);

    d4 = 4'h5;
    #1;
    chk("pass_comb", bsg_tb_ctr_t'(q0), 64'h5);

    run_to(20);
    chk("dly_c20", bsg_tb_ctr_t'(q3), 64'd0);
    d = 1'b1;
    for (int c = 21; c <= 25; c++) begin
      tick();
      d = 1'b0;
      chk($sformatf("dly_c%0d", c), bsg_tb_ctr_t'(q3), (c == 23) ? 64'd1 : 64'd0);
    end

    run_to(37);
    sv = 1'b1;
    tick();
    chk("snap1_vld", bsg_tb_ctr_t'(if3.sample_v_o), 64'd1);
    chk("snap1_val", if3.sample_r_o, 64'd37);
    tick();
    sv = 1'b0;
    chk("snap2_vld", bsg_tb_ctr_t'(if3.sample_v_o), 64'd1);
    chk("snap2_val", if3.sample_r_o, 64'd38);
    tick();
    chk("snap_end_vld", bsg_tb_ctr_t'(if3.sample_v_o), 64'd0);
    chk("snap_hold", if3.sample_r_o, 64'd38);

    run_to(290);
    sv = 1'b1;
    tick();
    sv = 1'b0;
    chk("snap8_vld", bsg_tb_ctr_t'(if8.sample_v_o), 64'd1);
    chk("snap8_val", bsg_tb_ctr_t'(if8.sample_r_o), exp8(290));
    chk("snap64_val", if3.sample_r_o, 64'd290);
    run_to(300);
    chk("ctr8_end", bsg_tb_ctr_t'(ctr8), exp8(300));

    rst = 1'b1;
    tick();
    rst = 1'b0;
    run_to(97);
    d = 1'b1;
    run_to(100);
    chk("pre_rst_data", bsg_tb_ctr_t'(q3), 64'd1);
    rst = 1'b1; sv = 1'b1;
    tick();
    chk("mid_rst_ctr", ctr3, 64'd0);
    chk("mid_rst_ctr8", bsg_tb_ctr_t'(ctr8), 64'd0);
    chk("mid_rst_data", bsg_tb_ctr_t'(q3), 64'd0);
    chk("mid_rst_vld", bsg_tb_ctr_t'(if3.sample_v_o), 64'd0);
    chk("mid_rst_samp", if3.sample_r_o, 64'd0);
    chk("pass_mid_rst", bsg_tb_ctr_t'(q0), 64'h5);
    rst = 1'b0; sv = 1'b0; d = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      tick();
      chk($sformatf("flush_data%0d", c), bsg_tb_ctr_t'(q3), 64'd0);
      chk($sformatf("flush_vld%0d", c), bsg_tb_ctr_t'(if3.sample_v_o), 64'd0);
      chk($sformatf("flush_ctr%0d", c), ctr3, bsg_tb_ctr_t'(c));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/bsg_tb_timebase.md
# bsg_tb_timebase

Synthesizable timebase block for the manycore co-simulation top level, running on the core clock. It delays a status vector (e.g. tag-programming `reset_done`) through a fixed-depth register chain. It also provides a free-running global cycle counter that profilers, tracers and host-side readers share, plus a single-cycle snapshot port that latches the counter on request.

## Interface
Clock is `clk_i`; reset is `reset_i`, synchronous and active-high.

Parameters:
- `width_p`, default 1: width of the delayed data vector.
- `num_stages_p`, default 3: register stages in the delay chain. Legal range is 0..16; 0 means combinational pass-through.
- `ctr_width_p`, default 64: cycle counter width. Legal range is 8..64.

Ports:
- `clk_i`  in  1: core clock; all state updates on its rising edge.
- `reset_i`  in  1: synchronous, active-high reset.
- `data_i`  in  `width_p`: value to delay.
- `data_o`  out  `width_p`: `data_i` delayed by `num_stages_p` cycles.
- `ctr_r_o`  out  `ctr_width_p`: registered global cycle count.
- `sample_v_i`  in  1: snapshot request.
- `sample_v_o`  out  1: snapshot valid, a one-cycle pulse.
- `sample_r_o`  out  `ctr_width_p`: latched counter value.

## Operation
- **Delay chain:** stage 0 loads `data_i`; stage k loads stage k-1; `data_o` is the last stage.
  - With `num_stages_p`=0, `data_o = data_i` combinationally and reset has no effect on it.
- **Chain reset:** while `reset_i`=1, every stage clears to 0.
- **Counter:** while `reset_i`=1, `ctr_r_o` is 0. On each rising edge with `reset_i`=0, `ctr_r_o <= ctr_r_o + 1`.
  - Default behaviour is modulo 2^`ctr_width_p`: all-ones wraps to 0.
- **Snapshot:** on an edge where `sample_v_i`=1 and `reset_i`=0:
  - `sample_r_o` is loaded with the pre-increment `ctr_r_o` (the value visible in the request cycle).
  - `sample_v_o` is 1 in the following cycle.
  - Otherwise `sample_v_o` is 0 and `sample_r_o` holds its value.
- **Back-to-back requests:** each request produces its own pulse and value; there is no backpressure.
- **Reset values:** `data_o`=0 (when `num_stages_p`>0), `ctr_r_o`=0, `sample_v_o`=0, `sample_r_o`=0.
- **Reset mid-operation:** asserting `reset_i` clears all state on the next edge. In-flight chain data and any pending snapshot are dropped; a `sample_v_i` in the reset cycle is ignored.

## Timing
- `data_o` at cycle n+`num_stages_p` equals `data_i` at cycle n.
- The first edge with `reset_i`=0 leaves `ctr_r_o`=1. The cycle in which reset is first low therefore shows 0.
- Snapshot latency is one cycle. The request in cycle n yields `sample_v_o`=1 and `sample_r_o`=`ctr_r_o`(n) in cycle n+1.
- All outputs except the 0-stage pass-through are register outputs, with no combinational input-to-output paths.

## Configuration
- **`BSG_TB_TIMEBASE_SATURATE_EN` defined:** the counter stops at all-ones and holds it until reset. Snapshots taken at saturation return all-ones.
- **Macro not defined:** the counter wraps modulo 2^`ctr_width_p`.

## Structure
- **Shared package `bsg_tb_timebase_pkg`:**
  - default constants `bsg_tb_timebase_stages_gp`=3 and `bsg_tb_timebase_ctr_width_gp`=64;
  - typedef `bsg_tb_ctr_t` = logic[63:0].
- **Sub-module:** the delay chain is one natural sub-module, `bsg_dff_chain_reset`. It is parameterized by `width_p` and `num_stages_p` and uses a generate loop of reset-able registers.
- **Top level:** the counter and snapshot logic live in the top level.

## Test plan
- Hold `reset_i`=1 for 16 cycles with `data_i`=1 and `sample_v_i`=1, then release. All outputs are 0 throughout reset; the cycle after release shows `ctr_r_o`=1.
- With `num_stages_p`=3, pulse `data_i`=1 at cycle 20 for one cycle. `data_o`=1 only at cycle 23.
- Pulse `sample_v_i` while `ctr_r_o`=37, then again in the next cycle. `sample_v_o`=1 for two cycles with `sample_r_o`=37, then 38.
- With `ctr_width_p`=8, run 300 cycles past reset.
  - Without the macro, `ctr_r_o` goes 255 to 0 and reads 44 at the end.
  - With `BSG_TB_TIMEBASE_SATURATE_EN`, it sticks at 255.
- Assert `reset_i` for 1 cycle at `ctr_r_o`=100 while chain stages hold 1s. The next cycle shows `ctr_r_o`=0, all stages 0, and `sample_v_o`=0.
- With `num_stages_p`=0 and `width_p`=4, drive `data_i`=4'hA. `data_o`=4'hA in the same cycle, including during reset.
